// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch (F) and data access (M).
// Optional wait-cycle counters are built only when MEMARB_PERF_EN is defined.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          FetchReqF,
    input  logic [AW-1:0] PCF,
    input  logic          FlushF,
    output logic [DW-1:0] InstrF,
    output logic          InstrValidF,
    output logic          StallF,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          DataDoneM,
    output logic          StallM,
    output logic          BusReq,
    output logic          BusWe,
    output logic [AW-1:0] BusAddr,
    output logic [DW-1:0] BusWData,
    input  logic [DW-1:0] BusRData,
    input  logic          BusAck,
    output logic [31:0]   FetchWaitCnt,
    output logic [31:0]   DataWaitCnt
);

    typedef enum logic [2:0] {IDLE, FETCH, DATA, DONE_F, DONE_D} state_t;

    state_t state, nextState;
    logic   dataReq;
    logic   stale;
    logic   launchData;
    logic   launchFetch;

    assign dataReq = MemReadM | MemWriteM;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // DONE_F never launches a fetch and DONE_D never relaunches the served data request.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (dataReq)        nextState = DATA;
                else if (FetchReqF) nextState = FETCH;
            end
            FETCH:   if (BusAck) nextState = DONE_F;
            DATA:    if (BusAck) nextState = DONE_D;
            DONE_F:  nextState = dataReq ? DATA : IDLE;
            DONE_D:  nextState = FetchReqF ? FETCH : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        BusReq      = 1'b0;
        InstrValidF = 1'b0;
        DataDoneM   = 1'b0;
        case (state)
            FETCH, DATA: BusReq      = 1'b1;
            DONE_F:      InstrValidF = ~stale & ~FlushF;
            DONE_D:      DataDoneM   = 1'b1;
            default: ;
        endcase
    end

    assign StallF = FetchReqF & ~InstrValidF;
    assign StallM = dataReq & ~DataDoneM;

    assign launchData  = (nextState == DATA)  && (state != DATA);
    assign launchFetch = (nextState == FETCH) && (state != FETCH);

    // Bus address/control are latched once at launch and held for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            BusAddr   <= '0;
            BusWe     <= 1'b0;
            BusWData  <= '0;
            InstrF    <= '0;
            ReadDataM <= '0;
            stale     <= 1'b0;
        end else begin
            if (launchData) begin
                BusAddr  <= ALUResultM;
                BusWe    <= MemWriteM;
                BusWData <= WriteDataM;
            end else if (launchFetch) begin
                BusAddr <= PCF;
                BusWe   <= 1'b0;
            end
            if (state == FETCH && BusAck)
                InstrF <= BusRData;
            if (state == DATA && BusAck && !BusWe)
                ReadDataM <= BusRData;
            // A flush while the fetch is in flight (ack cycle included) marks its result stale.
            if (state == DONE_F)
                stale <= 1'b0;
            else if (state == FETCH && FlushF)
                stale <= 1'b1;
        end
    end

`ifdef MEMARB_PERF_EN
    logic [31:0] fetchWaitQ;
    logic [31:0] dataWaitQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchWaitQ <= '0;
            dataWaitQ  <= '0;
        end else begin
            if (state == FETCH) fetchWaitQ <= fetchWaitQ + 32'd1;
            if (state == DATA)  dataWaitQ  <= dataWaitQ + 32'd1;
        end
    end

    assign FetchWaitCnt = fetchWaitQ;
    assign DataWaitCnt  = dataWaitQ;
`else
    assign FetchWaitCnt = '0;
    assign DataWaitCnt  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency/priority/flush/reset scenarios, then randomized
// traffic against a transaction-level memory and pipeline model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int AGE_MAX = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          FetchReqF, FlushF, InstrValidF, StallF;
    logic [AW-1:0] PCF;
    logic [DW-1:0] InstrF;
    logic          MemReadM, MemWriteM, DataDoneM, StallM;
    logic [AW-1:0] ALUResultM;
    logic [DW-1:0] WriteDataM, ReadDataM;
    logic          BusReq, BusWe, BusAck;
    logic [AW-1:0] BusAddr;
    logic [DW-1:0] BusWData, BusRData;
    logic [31:0]   FetchWaitCnt, DataWaitCnt;

    int nVec = 0;
    int nErr = 0;
    logic [31:0] dmem [64];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .FetchReqF(FetchReqF), .PCF(PCF), .FlushF(FlushF), .InstrF(InstrF),
        .InstrValidF(InstrValidF), .StallF(StallF),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .DataDoneM(DataDoneM), .StallM(StallM),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
        .BusRData(BusRData), .BusAck(BusAck),
        .FetchWaitCnt(FetchWaitCnt), .DataWaitCnt(DataWaitCnt)
    );

    function automatic logic [31:0] instrAt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hE2800000;
    endfunction

    function automatic logic [5:0] dIdx(input logic [31:0] a);
        logic [31:0] t;
        t = a - 32'h2000;
        return t[7:2];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; FetchReqF = 1'b0; PCF = '0; FlushF = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
        BusAck = 1'b0; BusRData = '0;
        cyc(); cyc();
        @(negedge clk);
        nVec++; if (BusReq !== 1'b0 || BusWe !== 1'b0) begin nErr++; $display("FAIL reset_bus: req=%b we=%b want 0 0", BusReq, BusWe); end
        nVec++; if (BusAddr !== '0 || BusWData !== '0) begin nErr++; $display("FAIL reset_busdata: addr=%h wdata=%h want 0", BusAddr, BusWData); end
        nVec++; if (InstrF !== '0 || ReadDataM !== '0) begin nErr++; $display("FAIL reset_data: instr=%h rdata=%h want 0", InstrF, ReadDataM); end
        nVec++; if (InstrValidF !== 1'b0 || DataDoneM !== 1'b0) begin nErr++; $display("FAIL reset_pulses: iv=%b dd=%b want 0", InstrValidF, DataDoneM); end
        nVec++; if (FetchWaitCnt !== 32'd0 || DataWaitCnt !== 32'd0) begin nErr++; $display("FAIL reset_cnt: %0d %0d want 0", FetchWaitCnt, DataWaitCnt); end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_fetch_zero_wait();
        cyc();
        FetchReqF = 1'b1; PCF = 32'h100;
        @(negedge clk);
        nVec++; if (StallF !== 1'b1 || BusReq !== 1'b0) begin nErr++; $display("FAIL fetch_c0: stall=%b req=%b want 1 0", StallF, BusReq); end
        cyc();
        BusAck = 1'b1; BusRData = 32'hE2801001;
        @(negedge clk);
        nVec++; if (BusReq !== 1'b1 || BusAddr !== 32'h100 || BusWe !== 1'b0) begin nErr++; $display("FAIL fetch_c1: req=%b addr=%h we=%b want 1 100 0", BusReq, BusAddr, BusWe); end
        nVec++; if (StallF !== 1'b1 || InstrValidF !== 1'b0) begin nErr++; $display("FAIL fetch_c1_stall: stall=%b iv=%b want 1 0", StallF, InstrValidF); end
        cyc();
        BusAck = 1'b0; BusRData = '0;
        @(negedge clk);
        nVec++; if (InstrValidF !== 1'b1 || InstrF !== 32'hE2801001) begin nErr++; $display("FAIL fetch_c2: iv=%b instr=%h want 1 e2801001", InstrValidF, InstrF); end
        nVec++; if (StallF !== 1'b0 || BusReq !== 1'b0) begin nErr++; $display("FAIL fetch_c2_stall: stall=%b req=%b want 0 0", StallF, BusReq); end
        cyc();
        FetchReqF = 1'b0;
        @(negedge clk);
        nVec++; if (InstrValidF !== 1'b0 || BusReq !== 1'b0) begin nErr++; $display("FAIL fetch_c3: iv=%b req=%b want 0 0", InstrValidF, BusReq); end
    endtask

    task automatic test_load_wait3();
        int stalls;
        stalls = 0;
        cyc();
        MemReadM = 1'b1; ALUResultM = 32'h200;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin BusAck = 1'b1; BusRData = 32'hDEADBEEF; end
            @(negedge clk);
            if (StallM === 1'b1) stalls++;
            nVec++; if (BusReq !== (c > 0)) begin nErr++; $display("FAIL load_req c%0d: got %b want %b", c, BusReq, c > 0); end
            cyc();
        end
        BusAck = 1'b0; BusRData = '0;
        @(negedge clk);
        nVec++; if (stalls != 5) begin nErr++; $display("FAIL load_stalls: got %0d want 5", stalls); end
        nVec++; if (DataDoneM !== 1'b1 || StallM !== 1'b0) begin nErr++; $display("FAIL load_done: dd=%b stall=%b want 1 0", DataDoneM, StallM); end
        nVec++; if (ReadDataM !== 32'hDEADBEEF) begin nErr++; $display("FAIL load_data: got %h want deadbeef", ReadDataM); end
`ifdef MEMARB_PERF_EN
        nVec++; if (DataWaitCnt !== 32'd4 || FetchWaitCnt !== 32'd1) begin nErr++; $display("FAIL perf_cnt: data=%0d fetch=%0d want 4 1", DataWaitCnt, FetchWaitCnt); end
`else
        nVec++; if (DataWaitCnt !== 32'd0 || FetchWaitCnt !== 32'd0) begin nErr++; $display("FAIL perf_off: data=%0d fetch=%0d want 0 0", DataWaitCnt, FetchWaitCnt); end
`endif
        cyc();
        MemReadM = 1'b0;
    endtask

    task automatic test_store();
        cyc();
        MemWriteM = 1'b1; ALUResultM = 32'h300; WriteDataM = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 3) begin BusAck = 1'b1; BusRData = 32'h0BADF00D; end
            @(negedge clk);
            nVec++; if (BusReq !== 1'b1 || BusWe !== 1'b1 || BusAddr !== 32'h300 || BusWData !== 32'h12345678) begin
                nErr++; $display("FAIL store_bus c%0d: req=%b we=%b addr=%h wd=%h want 1 1 300 12345678", c, BusReq, BusWe, BusAddr, BusWData); end
        end
        cyc();
        BusAck = 1'b0;
        @(negedge clk);
        nVec++; if (DataDoneM !== 1'b1 || ReadDataM !== 32'hDEADBEEF) begin nErr++; $display("FAIL store_done: dd=%b rdata=%h want 1 deadbeef", DataDoneM, ReadDataM); end
        cyc();
        MemWriteM = 1'b0;
        @(negedge clk);
        nVec++; if (DataDoneM !== 1'b0 || BusReq !== 1'b0) begin nErr++; $display("FAIL store_after: dd=%b req=%b want 0 0", DataDoneM, BusReq); end
    endtask

    task automatic test_simultaneous();
        cyc();
        FetchReqF = 1'b1; PCF = 32'h400; MemReadM = 1'b1; ALUResultM = 32'h500;
        cyc();
        BusAck = 1'b1; BusRData = 32'hCAFE0001;
        @(negedge clk);
        nVec++; if (BusReq !== 1'b1 || BusAddr !== 32'h500 || BusWe !== 1'b0) begin nErr++; $display("FAIL simul_data: req=%b addr=%h we=%b want 1 500 0", BusReq, BusAddr, BusWe); end
        cyc();
        BusAck = 1'b0;
        @(negedge clk);
        nVec++; if (DataDoneM !== 1'b1 || ReadDataM !== 32'hCAFE0001 || StallF !== 1'b1) begin nErr++; $display("FAIL simul_done: dd=%b rdata=%h stallF=%b want 1 cafe0001 1", DataDoneM, ReadDataM, StallF); end
        cyc();
        MemReadM = 1'b0; BusAck = 1'b1; BusRData = 32'hAAAA5555;
        @(negedge clk);
        nVec++; if (BusReq !== 1'b1 || BusAddr !== 32'h400 || BusWe !== 1'b0) begin nErr++; $display("FAIL simul_fetch: req=%b addr=%h we=%b want 1 400 0", BusReq, BusAddr, BusWe); end
        cyc();
        BusAck = 1'b0;
        @(negedge clk);
        nVec++; if (InstrValidF !== 1'b1 || InstrF !== 32'hAAAA5555 || DataDoneM !== 1'b0) begin nErr++; $display("FAIL simul_instr: iv=%b instr=%h dd=%b want 1 aaaa5555 0", InstrValidF, InstrF, DataDoneM); end
        cyc();
        FetchReqF = 1'b0;
    endtask

    task automatic test_flush();
        cyc();
        FetchReqF = 1'b1; PCF = 32'h600;
        cyc();
        @(negedge clk);
        nVec++; if (BusReq !== 1'b1 || BusAddr !== 32'h600) begin nErr++; $display("FAIL flush_launch: req=%b addr=%h want 1 600", BusReq, BusAddr); end
        cyc();
        FlushF = 1'b1; PCF = 32'h700;
        cyc();
        FlushF = 1'b0; BusAck = 1'b1; BusRData = 32'h11111111;
        cyc();
        BusAck = 1'b0;
        @(negedge clk);
        nVec++; if (InstrF !== 32'h11111111 || InstrValidF !== 1'b0 || StallF !== 1'b1) begin nErr++; $display("FAIL flush_stale: instr=%h iv=%b stall=%b want 11111111 0 1", InstrF, InstrValidF, StallF); end
        cyc();
        @(negedge clk);
        nVec++; if (BusReq !== 1'b0 || StallF !== 1'b1) begin nErr++; $display("FAIL flush_idle: req=%b stall=%b want 0 1", BusReq, StallF); end
        cyc();
        BusAck = 1'b1; BusRData = 32'h22222222;
        @(negedge clk);
        nVec++; if (BusReq !== 1'b1 || BusAddr !== 32'h700) begin nErr++; $display("FAIL flush_refetch: req=%b addr=%h want 1 700", BusReq, BusAddr); end
        cyc();
        BusAck = 1'b0;
        @(negedge clk);
        nVec++; if (InstrValidF !== 1'b1 || InstrF !== 32'h22222222) begin nErr++; $display("FAIL flush_valid: iv=%b instr=%h want 1 22222222", InstrValidF, InstrF); end
        cyc();
        FetchReqF = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        cyc();
        MemWriteM = 1'b1; ALUResultM = 32'h800; WriteDataM = 32'h55AA55AA;
        cyc();
        @(negedge clk);
        nVec++; if (BusReq !== 1'b1) begin nErr++; $display("FAIL rstmid_req: got %b want 1", BusReq); end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0; MemWriteM = 1'b0; BusAck = 1'b1; BusRData = 32'h77777777;
        @(negedge clk);
        nVec++; if (BusReq !== 1'b0 || BusWe !== 1'b0 || BusAddr !== '0 || BusWData !== '0) begin nErr++; $display("FAIL rstmid_bus: req=%b we=%b addr=%h wd=%h want 0", BusReq, BusWe, BusAddr, BusWData); end
        nVec++; if (InstrF !== '0 || ReadDataM !== '0 || DataDoneM !== 1'b0 || InstrValidF !== 1'b0) begin nErr++; $display("FAIL rstmid_out: instr=%h rdata=%h dd=%b iv=%b want 0", InstrF, ReadDataM, DataDoneM, InstrValidF); end
        nVec++; if (FetchWaitCnt !== 32'd0 || DataWaitCnt !== 32'd0) begin nErr++; $display("FAIL rstmid_cnt: %0d %0d want 0", FetchWaitCnt, DataWaitCnt); end
        cyc();
        BusAck = 1'b0;
        @(negedge clk);
        nVec++; if (BusReq !== 1'b0 || DataDoneM !== 1'b0 || ReadDataM !== '0) begin nErr++; $display("FAIL rstmid_lateack: req=%b dd=%b rdata=%h want 0 0 0", BusReq, DataDoneM, ReadDataM); end
    endtask

    // Random F/M traffic and random-latency memory; checks results, bus contents, stalls and wait bounds.
    task automatic test_random(input int cycles);
        logic fPend, dPend, dWe, inAcc, accWe;
        logic [31:0] dAddr, dWd, accAddr, accWd, lastRead, expD;
        int waitLeft, fAge, dAge;
        for (int i = 0; i < 64; i++) dmem[i] = $urandom;
        fPend = 1'b0; dPend = 1'b0; dWe = 1'b0; inAcc = 1'b0; accWe = 1'b0;
        dAddr = '0; dWd = '0; accAddr = '0; accWd = '0; lastRead = '0;
        waitLeft = 0; fAge = 0; dAge = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (fPend) fAge++;
            if (dPend) dAge++;
            nVec++; if (StallF !== (FetchReqF & ~InstrValidF)) begin nErr++; $display("FAIL rnd_stallF c%0d: got %b", c, StallF); end
            nVec++; if (StallM !== ((MemReadM | MemWriteM) & ~DataDoneM)) begin nErr++; $display("FAIL rnd_stallM c%0d: got %b", c, StallM); end
            if (InstrValidF) begin
                nVec++; if (!fPend || InstrF !== instrAt(PCF) || fAge > AGE_MAX) begin
                    nErr++; $display("FAIL rnd_instr c%0d: got %h want %h pend=%b age=%0d", c, InstrF, instrAt(PCF), fPend, fAge); end
                fPend = 1'b0; fAge = 0;
            end
            if (DataDoneM) begin
                expD = dWe ? lastRead : dmem[dIdx(dAddr)];
                nVec++; if (!dPend || ReadDataM !== expD || dAge > AGE_MAX) begin
                    nErr++; $display("FAIL rnd_rdata c%0d: got %h want %h pend=%b age=%0d", c, ReadDataM, expD, dPend, dAge); end
                lastRead = expD; dPend = 1'b0; dAge = 0;
            end
            BusAck = 1'b0; BusRData = $urandom;
            if (BusReq) begin
                if (!inAcc) begin
                    inAcc = 1'b1; accAddr = BusAddr; accWe = BusWe; accWd = BusWData;
                    waitLeft = $urandom_range(0, 3);
                    nVec++;
                    if (accAddr >= 32'h2000) begin
                        if (!(dPend && accAddr == dAddr && accWe == dWe && (!dWe || accWd == dWd))) begin
                            nErr++; $display("FAIL rnd_dlaunch c%0d: addr=%h we=%b want %h %b", c, accAddr, accWe, dAddr, dWe); end
                    end else if (!(fPend && !accWe && accAddr == PCF)) begin
                        nErr++; $display("FAIL rnd_flaunch c%0d: addr=%h want %h pend=%b", c, accAddr, PCF, fPend);
                    end
                end else begin
                    nVec++; if (BusAddr !== accAddr || BusWe !== accWe || BusWData !== accWd) begin
                        nErr++; $display("FAIL rnd_hold c%0d: addr=%h want %h", c, BusAddr, accAddr); end
                end
                if (waitLeft == 0) begin
                    BusAck = 1'b1; inAcc = 1'b0;
                    if (accWe) dmem[dIdx(accAddr)] = accWd;
                    else BusRData = (accAddr >= 32'h2000) ? dmem[dIdx(accAddr)] : instrAt(accAddr);
                end else waitLeft--;
            end else begin
                nVec++; if (inAcc) begin nErr++; $display("FAIL rnd_dropped c%0d: req=0 want 1", c); end
                inAcc = 1'b0;
                BusAck = ($urandom % 4 == 0);
            end
            FlushF = 1'b0;
            if (!fPend) begin
                if ($urandom % 3 != 0) begin fPend = 1'b1; fAge = 0; PCF = 32'h1000 + ($urandom_range(0, 255) << 2); end
            end else if ($urandom % 16 == 0) begin
                FlushF = 1'b1; fAge = 0; PCF = 32'h1000 + ($urandom_range(0, 255) << 2);
            end
            FetchReqF = fPend;
            if (!dPend && $urandom % 3 == 0) begin
                dPend = 1'b1; dAge = 0; dWe = 1'($urandom % 2);
                dAddr = 32'h2000 + ($urandom_range(0, 63) << 2); dWd = $urandom;
            end
            MemReadM = dPend & ~dWe; MemWriteM = dPend & dWe;
            ALUResultM = dPend ? dAddr : $urandom;
            WriteDataM = dPend ? dWd : $urandom;
        end
        nVec++; if (fAge > AGE_MAX || dAge > AGE_MAX) begin nErr++; $display("FAIL rnd_starve: fAge=%0d dAge=%0d max %0d", fAge, dAge, AGE_MAX); end
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_load_wait3();
        test_store();
        test_simultaneous();
        test_flush();
        test_reset_mid_data();
        test_random(4000);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory bus between the pipeline fetch stage (F) and the memory stage (M).
- Sequences each access with a req/ack handshake and variable memory latency.
- Returns fetched instructions and load data, and produces the stall signals the hazard logic uses to freeze F and M.
- Data accesses have priority over fetch. Starvation is prevented by alternating after each completed access.

Parameters:
AW, 32, bus/PC address width
DW, 32, instruction/data width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
FetchReqF  input  1  F stage requests the instruction at PCF
PCF  input  AW  fetch address
FlushF  input  1  redirect; any outstanding fetch result is stale
InstrF  output  DW  last fetched instruction (registered)
InstrValidF  output  1  one-cycle pulse: InstrF holds the instruction for the current PCF
StallF  output  1  FetchReqF & ~InstrValidF
MemReadM  input  1  load in M (already condition-gated)
MemWriteM  input  1  store in M (already condition-gated)
ALUResultM  input  AW  data address
WriteDataM  input  DW  store data
ReadDataM  output  DW  load result (registered)
DataDoneM  output  1  one-cycle pulse: data access complete
StallM  output  1  (MemReadM|MemWriteM) & ~DataDoneM
BusReq  output  1  access request, held until acked
BusWe  output  1  1 = write
BusAddr  output  AW  access address
BusWData  output  DW  write data
BusRData  input  DW  read data, valid with BusAck
BusAck  input  1  access complete (sampled only while BusReq=1)
FetchWaitCnt  output  32  see Optional Feature
DataWaitCnt  output  32  see Optional Feature

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - State is IDLE.
  - BusReq, BusWe, InstrValidF and DataDoneM are 0.
  - BusAddr, BusWData, InstrF and ReadDataM are 0.
  - The stale flag is 0.
- Reset during an access: BusReq drops at that edge and the access is abandoned. The bus ignores an abandoned request.
- States: IDLE, FETCH, DATA, DONE_F, DONE_D.
- IDLE:
  - If MemReadM|MemWriteM, go to DATA. Latch BusAddr=ALUResultM, BusWe=MemWriteM, BusWData=WriteDataM.
  - Else if FetchReqF, go to FETCH. Latch BusAddr=PCF, BusWe=0.
  - Else stay in IDLE.
- FETCH and DATA:
  - BusReq=1. BusAddr, BusWe and BusWData are held stable.
  - On BusAck: FETCH goes to DONE_F, capturing InstrF<=BusRData. DATA goes to DONE_D, capturing ReadDataM<=BusRData only for reads (writes leave ReadDataM unchanged).
  - The transition happens at the ack edge. BusReq is 0 the next cycle.
- DONE_F:
  - InstrValidF=1, unless the stale flag is set.
  - The F stage advances at the end of this cycle, so no fetch may launch here.
  - If a data request is present, go to DATA (latched as in IDLE); else go to IDLE.
- DONE_D:
  - DataDoneM=1, so StallM=0 and M advances at the end of this cycle.
  - The current data request is already served and must not relaunch.
  - If FetchReqF, go to FETCH (latched from PCF); else go to IDLE.
- Latency:
  - Zero-wait memory (BusAck in the first BusReq cycle): a fetch is issued in cycle 0, BusReq=1 in cycle 1, InstrValidF=1 in cycle 2.
  - Each additional memory wait cycle adds one cycle.
- Flush handling:
  - FlushF in FETCH, or in the ack cycle itself, sets the stale flag. On the ack, InstrF still updates, but InstrValidF stays 0 in DONE_F, so StallF remains asserted.
  - The stale flag clears on DONE_F exit.
  - FlushF in IDLE, DATA or DONE_D has no effect. In DONE_F it suppresses InstrValidF.
- BusAck outside FETCH/DATA is ignored.
- Data priority:
  - A data request arriving while FETCH is busy waits for the fetch ack. It is served from DONE_F before the next fetch.
  - Simultaneous requests in IDLE: data wins. The fetch follows from DONE_D.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- Defined:
  - FetchWaitCnt increments every cycle that state==FETCH.
  - DataWaitCnt increments every cycle that state==DATA.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Single fetch, zero-wait: FetchReqF=1, PCF=0x100, BusAck given in the first req cycle -> BusReq=1 with BusAddr=0x100 in cycle 1; InstrF=BusRData (0xE2801001) with InstrValidF=1 in cycle 2 only; StallF=1 in cycles 0-1.
- Load with 3 wait states: MemReadM=1, ALUResultM=0x200, BusAck on the 4th req cycle with BusRData=0xDEADBEEF -> StallM=1 for 5 cycles; DataDoneM=1 and ReadDataM=0xDEADBEEF in cycle 5.
- Store: MemWriteM=1, WriteDataM=0x12345678 -> BusWe=1 and BusWData held until ack; DataDoneM pulses; ReadDataM unchanged.
- Simultaneous requests in IDLE: fetch and data both asserted -> DATA first, then DONE_D, then FETCH; no relaunch of the same data request.
- Flush during fetch: FlushF=1 at wait cycle 1 -> ack captured, InstrValidF stays 0, StallF stays 1, next fetch uses the new PCF.
- Reset mid-DATA: reset asserted while BusReq=1 -> next cycle BusReq=0, state IDLE, all outputs 0; a late BusAck is ignored; with MEMARB_PERF_EN, both counters are 0.
